// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//
// Round-robin arbiter for 8 level-sensitive request lines. Produces a
// registered one-hot grant that feeds an 8-to-3 one-hot encoder directly.
// A grant is held while its owner keeps requesting; on release the priority
// pointer moves to the requester after the owner. Every grant is followed by
// at least one idle cycle before the next grant.
//
// Optional feature (macro ARB_TIMEOUT_EN): a grant that has lasted MAX_HOLD
// cycles while still requested is force-revoked, and `timeout` pulses for the
// one idle cycle that follows. Without the macro there is no hold counter and
// `timeout` is tied low; the port list is identical in both builds.
//
// Ports:
//   clk         in   1  single clock, all logic on posedge
//   rst         in   1  synchronous, active-high reset
//   req         in   N  request lines, bit i = requester i
//   grant       out  N  registered one-hot grant, 0 when idle
//   grant_valid out  1  high exactly when grant is non-zero
//   timeout     out  1  one-cycle pulse on a forced revoke
//
// Handshake: grant/grant_valid is a valid-only interface with no ready.
// grant_valid == |grant on every cycle; the downstream encoder output is
// meaningful only while grant_valid is high. A requester holds ownership by
// keeping its req bit high and gives it up by dropping it.
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);

    // Elaboration-time configuration checks.
    if (N != 8) begin : g_bad_n
        $error("rr_onehot_arbiter: N must be 8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_onehot_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [2:0]     ptr, ptr_n;
    logic [2:0]     owner, owner_n;
    logic [N-1:0]   grant_q, grant_n;
    logic           timeout_q, timeout_n;

    logic [N-1:0]   rot;
    logic [2:0]     off;
    logic [2:0]     sel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0]     hold_cnt, hold_n;
`endif

    // Rotate req so that bit 0 of rot is requester ptr; the lowest set bit of
    // rot is then the winner, and adding ptr back (mod 8) gives its index.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[ptr + 3'(i)];
        end
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
    end

    assign sel = ptr + off;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        grant_n   = grant_q;
        timeout_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_n    = hold_cnt;
`endif
        case (state)
            IDLE: begin
                grant_n = '0;
                if (|req) begin
                    state_n = GRANT;
                    owner_n = sel;
                    grant_n = N'(1) << sel;
`ifdef ARB_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    // Normal release takes priority over an expiry on the
                    // same cycle, so no timeout pulse is raised here.
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = owner + 3'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    ptr_n     = owner + 3'd1;
                    timeout_n = 1'b1;
                end else if (hold_cnt != 8'hFF) begin
                    hold_n = hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            owner     <= 3'd0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            grant_q   <= grant_n;
            timeout_q <= timeout_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_n;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    // timeout_q never leaves 0 in this build; the output is tied off.
    assign timeout     = 1'b0 & timeout_q;
`endif

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter for 8 request lines. Produces a registered one-hot grant vector.
- Sits directly upstream of the 8-to-3 one-hot encoder: `grant` drives the encoder's 8-bit input, and `grant_valid` qualifies the encoded index.
- Each grant is held while the owner keeps its request high. An optional timeout forces rotation.

Parameters:
- N, 8, number of requesters; fixed at 8 to match the encoder input width.
- MAX_HOLD, 16, maximum grant length in cycles before forced revoke. Used only with ARB_TIMEOUT_EN. Legal range 1..255.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request lines; bit i is requester i. Level-sensitive.
- grant  output  8  registered one-hot grant, or 8'h00 when idle.
- grant_valid  output  1  high exactly when grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-revoked. Tied 0 when the timeout feature is compiled out.

Behaviour:
- Reset: rst sampled high at a posedge sets the following, regardless of req and state:
  - grant=8'h00, grant_valid=0, timeout=0
  - state=IDLE, ptr=3'd0, hold_cnt=0
- rst overrides every other event in the same cycle.
- State register: IDLE, GRANT.
- ptr[2:0] is the highest-priority index. Search order is ptr, ptr+1, ... ptr+7, mod 8 with wrap.
- IDLE:
  - req==0: stay IDLE, outputs 0.
  - Otherwise: select the first set bit in search order. The next edge loads grant=(1<<sel), grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency: req sampled at edge t gives grant visible after edge t (1 cycle).
- GRANT, owner o:
  - req[o]==1 and no timeout: hold grant, hold_cnt++ (saturating).
  - req[o]==0: next edge sets grant=0, grant_valid=0, ptr=o+1 mod 8, state=IDLE.
- Minimum gap: at least one idle (grant=0) cycle between successive grants, including to a different requester.
- Non-owner requests are ignored while in GRANT. They are re-evaluated in IDLE.
- grant is always one-hot or zero. grant_valid always equals |grant.
- req bits toggling in IDLE: only the value sampled at the arbitration edge matters.
- ptr is updated only on a grant release or revoke, never in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts GRANT cycles: 0 on the first grant cycle, incrementing each cycle.
  - When hold_cnt==MAX_HOLD-1 and req[o] is still 1, the next edge sets grant=0, grant_valid=0, ptr=o+1 mod 8, state=IDLE, and timeout=1 for exactly that one following cycle.
  - Result: grant is high for exactly MAX_HOLD cycles.
  - If req[o] drops on the same cycle as expiry, it is a normal release and timeout stays 0.
- Undefined:
  - No counter logic and no revoke; a grant is held indefinitely while req[o]=1.
  - timeout is constant 0. MAX_HOLD is ignored.
  - Port list is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF -> grant=8'h00, grant_valid=0. Release rst -> next edge grant=8'h01, grant_valid=1.
- Release/rotate: req=8'h81 from reset -> grant=8'h01. Drop bit0 (req=8'h80) -> one cycle grant=8'h00, then grant=8'h80, ptr=1 on release.
- Wrap: grant bit6, then release -> ptr=7. Then req=8'h41 -> grant=8'h01 (bit7 empty, wraps to 0), not 8'h40.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h02 held -> grant=8'h02 for exactly 4 cycles, then grant=8'h00 with timeout=1 for 1 cycle, then grant=8'h02 again. Without the macro -> grant=8'h02 held indefinitely, timeout=0.
- Mid-operation reset: in GRANT with grant=8'h10, assert rst while also dropping req[4] -> next edge grant=0, ptr=0. With req=8'h30 after reset -> grant=8'h10.
- Idle: req=8'h00 for 20 cycles -> grant=8'h00, grant_valid=0, timeout=0 throughout.
